// File: rtl/clk_flk_frontend_pkg.sv
// Shared definitions for the flick-button front end: debounce states,
// parameter defaults and a counter-width helper.
package clk_flk_frontend_pkg;

   localparam int DIV_HALF_DEF   = 50_000_000;
   localparam int DEB_CYCLES_DEF = 1_000_000;

   typedef enum logic [1:0] {
      IDLE_LO,
      CHK_HI,
      IDLE_HI,
      CHK_LO
   } deb_state_t;

   // Counter width for a modulus n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_flk_frontend_debouncer.sv
// Two-flop synchronizer plus debounce FSM; emits the debounced level and a
// one-cycle press pulse when a rising level is accepted.
module flk_debouncer
   import clk_flk_frontend_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic flk_raw,
   output logic deb,
   output logic press
);

   localparam int CW = cnt_width(DEB_CYCLES);

   logic          sync_p0;
   logic          sync;
   deb_state_t    state;
   deb_state_t    state_nxt;
   logic [CW-1:0] deb_cnt;
   logic [CW-1:0] deb_cnt_nxt;
   logic          deb_nxt;
   logic          press_nxt;
   logic          done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync    <= 1'b0;
      end else begin
         sync_p0 <= flk_raw;
         sync    <= sync_p0;
      end
   end

   // The sample that moved the FSM into a CHK state counts as the first one,
   // so acceptance happens when the current sample completes DEB_CYCLES.
   assign done = (int'(deb_cnt) + 2 >= DEB_CYCLES);

   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = deb_cnt;
      deb_nxt     = deb;
      press_nxt   = 1'b0;
      case (state)
         IDLE_LO: begin
            if (sync) begin
               state_nxt   = CHK_HI;
               deb_cnt_nxt = '0;
            end
         end
         CHK_HI: begin
            if (!sync) begin
               state_nxt = IDLE_LO;
            end else if (done) begin
               state_nxt   = IDLE_HI;
               deb_cnt_nxt = '0;
               deb_nxt     = 1'b1;
               press_nxt   = 1'b1;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end
         IDLE_HI: begin
            if (!sync) begin
               state_nxt   = CHK_LO;
               deb_cnt_nxt = '0;
            end
         end
         CHK_LO: begin
            if (sync) begin
               state_nxt = IDLE_HI;
            end else if (done) begin
               state_nxt   = IDLE_LO;
               deb_cnt_nxt = '0;
               deb_nxt     = 1'b0;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE_LO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE_LO;
         deb_cnt <= '0;
         deb     <= 1'b0;
         press   <= 1'b0;
      end else begin
         state   <= state_nxt;
         deb_cnt <= deb_cnt_nxt;
         deb     <= deb_nxt;
         press   <= press_nxt;
      end
   end

endmodule

// File: rtl/clk_flk_frontend.sv
// Flick-button front end: clock divider plus transfer of debounced presses
// onto flk, updated only when the divided clock falls.
module clk_flk_frontend
   import clk_flk_frontend_pkg::*;
#(
   parameter int DIV_HALF   = DIV_HALF_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic flk_raw,
   output logic div_clk,
   output logic flk,
   output logic flk_pending
);

   localparam int            DW       = cnt_width(DIV_HALF);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);

   logic [DW-1:0] div_cnt;
   logic          wrap;
   logic          fall_evt;
   logic          deb;
   logic          press;

   flk_debouncer #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .flk_raw (flk_raw),
      .deb     (deb),
      .press   (press)
   );

   assign wrap     = (div_cnt == DIV_LAST);
   assign fall_evt = wrap & div_clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         div_clk <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         div_clk <= ~div_clk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // A press landing on the fall edge goes straight to flk and never pends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flk         <= 1'b0;
         flk_pending <= 1'b0;
      end else if (fall_evt) begin
         flk         <= flk_pending | press | deb;
         flk_pending <= 1'b0;
      end else if (press) begin
         flk_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_clk_flk_frontend.sv
// Self-checking bench for clk_flk_frontend with DIV_HALF=4, DEB_CYCLES=3:
// a cycle model feeds a scoreboard, scenario table checks flk/pending totals.
module tb_clk_flk_frontend;

   localparam int DH = 4;
   localparam int DB = 3;

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic flk_raw = 1'b0;
   logic div_clk;
   logic flk;
   logic flk_pending;

   int checks   = 0;
   int failures = 0;

   clk_flk_frontend #(
      .DIV_HALF   (DH),
      .DEB_CYCLES (DB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flk_raw     (flk_raw),
      .div_clk     (div_clk),
      .flk         (flk),
      .flk_pending (flk_pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic d;
      logic f;
      logic p;
   } exp_t;

   exp_t sb[$];

   // reference model state
   int   m_k;
   int   m_run;
   logic m_s0, m_s1, m_deb, m_press, m_pend, m_flk;

   typedef struct {
      int pre;
      int hi;
      int total;
      int exp_flk;
      int exp_pend;
   } vec_t;

   vec_t vecs[6];

   int obs_flk;
   int obs_pend;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_k = 0; m_run = 0;
      m_s0 = 0; m_s1 = 0; m_deb = 0; m_press = 0; m_pend = 0; m_flk = 0;
      sb.delete();
   endtask

   // Advance the model by one clk edge with raw value r and queue the expectation.
   task automatic model_step(input logic r);
      logic np;
      exp_t e;
      m_k++;
      if (m_k % (2 * DH) == 0) begin
         m_flk  = m_pend | m_press | m_deb;
         m_pend = 1'b0;
      end else if (m_press) begin
         m_pend = 1'b1;
      end
      np = 1'b0;
      if (m_s1 != m_deb) begin
         m_run++;
         if (m_run == DB) begin
            m_deb = m_s1;
            m_run = 0;
            np    = m_deb;
         end
      end else begin
         m_run = 0;
      end
      m_press = np;
      m_s1 = m_s0;
      m_s0 = r;
      e.d = ((m_k / DH) % 2) == 1;
      e.f = m_flk;
      e.p = m_pend;
      sb.push_back(e);
   endtask

   // Called at a negedge: drive raw, advance one clk, compare at next negedge.
   task automatic cycle(input logic r);
      exp_t e;
      flk_raw = r;
      model_step(r);
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("div_clk", int'(div_clk), int'(e.d));
         chk("flk", int'(flk), int'(e.f));
         chk("flk_pending", int'(flk_pending), int'(e.p));
      end
      if (flk) obs_flk++;
      if (flk_pending) obs_pend++;
   endtask

   task automatic check_zero(input string nm);
      chk({nm, "_div_clk"}, int'(div_clk), 0);
      chk({nm, "_flk"}, int'(flk), 0);
      chk({nm, "_pending"}, int'(flk_pending), 0);
   endtask

   // Called at a negedge; returns at a negedge with reset released.
   task automatic do_reset();
      flk_raw = 1'b0;
      rst = 1'b1;
      #1;
      check_zero("reset_async");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      obs_flk  = 0;
      obs_pend = 0;
   endtask

   initial begin
      int first_rise, first_fall, second_rise, first_pend;

      vecs[0] = '{pre: 0,  hi: 0,  total: 24, exp_flk: 0,  exp_pend: 0};
      vecs[1] = '{pre: 0,  hi: 2,  total: 40, exp_flk: 0,  exp_pend: 0};
      vecs[2] = '{pre: 0,  hi: 40, total: 56, exp_flk: 40, exp_pend: 2};
      vecs[3] = '{pre: 7,  hi: 6,  total: 40, exp_flk: 8,  exp_pend: 3};
      vecs[4] = '{pre: 10, hi: 6,  total: 40, exp_flk: 8,  exp_pend: 0};
      vecs[5] = '{pre: 0,  hi: 3,  total: 40, exp_flk: 8,  exp_pend: 2};

      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int i = 0; i < vecs[v].total; i++)
            cycle((i >= vecs[v].pre) && (i < vecs[v].pre + vecs[v].hi));
         chk($sformatf("vec%0d_flk_cycles", v), obs_flk, vecs[v].exp_flk);
         chk($sformatf("vec%0d_pending_cycles", v), obs_pend, vecs[v].exp_pend);
      end

      // Divider phase after reset release.
      do_reset();
      first_rise = -1; first_fall = -1; second_rise = -1;
      for (int i = 1; i <= 20; i++) begin
         cycle(1'b0);
         if (div_clk && first_rise < 0) first_rise = i;
         if (!div_clk && first_rise >= 0 && first_fall < 0) first_fall = i;
         if (div_clk && first_fall >= 0 && second_rise < 0) second_rise = i;
      end
      chk("first_rise", first_rise, 4);
      chk("first_fall", first_fall, 8);
      chk("second_rise", second_rise, 12);

      // Reset mid-debounce with div_clk high, button held through release.
      do_reset();
      for (int i = 0; i < 6; i++) cycle(i >= 2);
      chk("pre_rst_div_clk", int'(div_clk), 1);
      rst = 1'b1;
      #1;
      check_zero("mid_rst");
      flk_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_zero("held_rst");
      end
      rst = 1'b0;
      model_reset();
      first_rise = -1; first_pend = -1;
      for (int i = 1; i <= 24; i++) begin
         cycle(1'b1);
         if (div_clk && first_rise < 0) first_rise = i;
         if (flk_pending && first_pend < 0) first_pend = i;
      end
      chk("requal_first_rise", first_rise, 4);
      chk("requal_first_pending", first_pend, 6);
      chk("held_flk_high", int'(flk), 1);
      rst = 1'b1;
      #1;
      check_zero("flk_rst");
      @(negedge clk);
      flk_raw = 1'b0;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) cycle(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_flk_frontend.md
CLK_FLK_FRONTEND -- requirements
Module: clk_flk_frontend

Interface
REQ-001 SHALL have parameter DIV_HALF, default 50_000_000, the number of clk cycles per div_clk half-period (legal range >= 1).
REQ-002 SHALL have parameter DEB_CYCLES, default 1_000_000, the number of consecutive stable synchronized samples that accept a level change (legal range >= 1).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port flk_raw, input, 1 bit: the raw, asynchronous, bouncing flick button.
REQ-006 SHALL have port div_clk, output, 1 bit: the divided clock, registered, 50% duty.
REQ-007 SHALL have port flk, output, 1 bit: the conditioned flick; it changes only on div_clk falling events.
REQ-008 SHALL have port flk_pending, output, 1 bit: status; high while an accepted press awaits transfer to flk.

Function
REQ-009 SHALL keep divider counter div_cnt, width $clog2(DIV_HALF) with a minimum of 1 bit, counting 0..DIV_HALF-1; at DIV_HALF-1 it wraps to 0 and div_clk toggles in the same cycle.
REQ-010 SHALL define fall_evt as the clk cycle in which div_clk toggles from 1 to 0, and rise_evt as the toggle from 0 to 1; with DIV_HALF=1, div_clk toggles every clk.
REQ-011 SHALL pass flk_raw through a two-flop synchronizer to produce sync; no other logic samples flk_raw.
REQ-012 SHALL run a debounce FSM with states IDLE_LO, CHK_HI, IDLE_HI and CHK_LO, a debounce counter deb_cnt and a debounced level deb.
REQ-013 In IDLE_LO, sync=1 SHALL move the FSM to CHK_HI with deb_cnt=0.
REQ-014 In CHK_HI, sync=0 SHALL return the FSM to IDLE_LO.
REQ-015 In CHK_HI, sync=1 SHALL increment deb_cnt; when deb_cnt=DEB_CYCLES-1 the FSM SHALL move to IDLE_HI, set deb=1, and assert press for exactly one clk cycle.
REQ-016 IDLE_HI and CHK_LO SHALL mirror IDLE_LO and CHK_HI for release: deb is cleared on acceptance and no pulse is generated.
REQ-017 A press pulse SHALL set pending (driven on flk_pending).
REQ-018 On each fall_evt, flk SHALL be loaded with pending OR press OR deb, and pending SHALL be cleared in the same cycle.
REQ-019 A press coincident with fall_evt SHALL be consumed by that update: flk=1 and pending=0.
REQ-020 Any press, however short, SHALL therefore hold flk high for at least one full div_clk period; a held button keeps flk high until the release is accepted and the next fall_evt occurs.
REQ-021 A second press while pending=1 SHALL merge into the existing pending press; no press counting.
REQ-022 Worst-case latency from flk_raw rising to flk rising SHALL be 2 + DEB_CYCLES + 2*DIV_HALF clk cycles.
REQ-023 deb_cnt width SHALL be $clog2(DEB_CYCLES) with a minimum of 1 bit, and deb_cnt SHALL never exceed DEB_CYCLES-1.

Reset
REQ-024 While rst=1, all registers SHALL be forced immediately, independent of clk: div_cnt=0, div_clk=0, synchronizer=0, FSM=IDLE_LO, deb_cnt=0, deb=0, pending=0, flk=0.
REQ-025 Reset asserted mid-debounce or mid-period SHALL discard partial counts; the first div_clk toggle after release SHALL occur DIV_HALF clk cycles after the first active edge.
REQ-026 A button held through reset release SHALL be re-qualified from IDLE_LO and produce one new press.

Structure
REQ-027 The debounce-state enum typedef and the default values of DIV_HALF and DEB_CYCLES SHALL live in a shared package.
REQ-028 The synchronizer and debounce FSM SHALL be one sub-module, flk_debouncer, with outputs deb and press; the divider and transfer logic SHALL stay in clk_flk_frontend.

Verification (DIV_HALF=4, DEB_CYCLES=3)
REQ-029 Idle after reset with flk_raw=0 -> div_clk has a period of 8 clk, with the first rise 4 clk after reset release; flk=0 and flk_pending=0 throughout.
REQ-030 flk_raw high for 2 clk, then low -> no press pulse and flk stays 0.
REQ-031 flk_raw held high for 40 clk -> deb=1 at clk 5 and flk=1 from the next fall_evt; after release, flk returns to 0 at the first fall_evt following deb=0.
REQ-032 flk_raw high for 6 clk with press just after a rise_evt -> flk_pending=1 for up to 4 clk, then flk=1 for exactly 8 clk.
REQ-033 Press pulse aligned to a fall_evt -> flk=1 on that edge and flk_pending never asserts.
REQ-034 rst pulsed while in CHK_HI with div_cnt=2 -> div_clk=0 and flk=0 immediately; after release, div_clk rises at clk 4 and the held button yields deb=1 five cycles after release.
